// File: rtl/imem_loader_if.sv
// Host byte link and imem write port A bundled between the loader and its
// neighbours.
//   rx_data/rx_valid/rx_ready : byte stream handshake (host -> loader)
//   imem_ena/wea/addra/dina   : imem write port A (loader -> imem)
// master = host/imem side, slave = loader side.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 14
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_ena;
  logic [3:0]        imem_wea;
  logic [ADDR_W-1:0] imem_addra;
  logic [31:0]       imem_dina;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_ena, imem_wea, imem_addra, imem_dina
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_ena, imem_wea, imem_addra, imem_dina
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction loader: parses a framed byte stream
// (MAGIC, len_lo, len_hi, 4*N data bytes LSB first, csum), writes the
// assembled words into imem port A and releases the core once the image
// checksum matches.
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   bus      : rx handshake + imem port A (slave modport)
//   core_rst : active-high reset to the core, released only in DONE
//   done     : image loaded and verified (sticky until rst)
//   error    : frame rejected (cleared by the next accepted MAGIC)
module imem_loader #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [7:0]  MAGIC     = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus,
  output logic         core_rst,
  output logic         done,
  output logic         error
);

  localparam int unsigned MAX_WORDS = (32'd1 << ADDR_W) - BASE_ADDR;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ready_q, ready_d;
  logic              ena_q, ena_d;
  logic [3:0]        wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [31:0]       dina_q, dina_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept_c;
  logic [15:0]       len_full_c;

  assign accept_c   = bus.rx_valid && ready_q;
  assign len_full_c = {bus.rx_data, len_q[7:0]};

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
      asm_q      <= '0;
      csum_q     <= '0;
      addr_q     <= BASE;
      ready_q    <= 1'b1;
      ena_q      <= 1'b0;
      wea_q      <= '0;
      addra_q    <= BASE;
      dina_q     <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
      ready_q    <= ready_d;
      ena_q      <= ena_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next-state and next-output decode; everything moves only on an accepted byte
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    addr_d     = addr_q;
    ena_d      = 1'b0;
    wea_d      = 4'h0;
    addra_d    = addra_q;
    dina_d     = dina_q;
    core_rst_d = core_rst_q;
    done_d     = done_q;
    error_d    = error_q;

    if (accept_c) begin
      case (state_q)
        S_IDLE: begin
          if (bus.rx_data == MAGIC) state_d = S_LEN0;
        end
        S_LEN0: begin
          len_d[7:0] = bus.rx_data;
          state_d    = S_LEN1;
        end
        S_LEN1: begin
          len_d      = len_full_c;
          csum_d     = '0;
          byte_idx_d = '0;
          word_cnt_d = '0;
          addr_d     = BASE;
          addra_d    = BASE;
          if (32'(len_full_c) > MAX_WORDS) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (len_full_c == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          csum_d     = csum_q + bus.rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = bus.rx_data;
            2'd1: asm_d[15:8]  = bus.rx_data;
            2'd2: asm_d[23:16] = bus.rx_data;
            default: begin
              // Word complete: one-cycle write pulse at the current address
              ena_d      = 1'b1;
              wea_d      = 4'hF;
              dina_d     = {bus.rx_data, asm_q};
              addra_d    = addr_q;
              addr_d     = addr_q + ADDR_W'(1);
              word_cnt_d = word_cnt_q + 16'd1;
              if (word_cnt_q + 16'd1 == len_q) state_d = S_CSUM;
            end
          endcase
        end
        S_CSUM: begin
          if (bus.rx_data == csum_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
        S_ERR: begin
          if (bus.rx_data == MAGIC) begin
            state_d = S_LEN0;
            error_d = 1'b0;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // rx_ready registered as a decode of the next state
    ready_d = (state_d != S_DONE);
  end

  assign bus.rx_ready   = ready_q;
  assign bus.imem_ena   = ena_q;
  assign bus.imem_wea   = wea_q;
  assign bus.imem_addra = addra_q;
  assign bus.imem_dina  = dina_q;
  assign core_rst       = core_rst_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random frames compared
// against a frame-level reference parser.
module tb_imem_loader;

  localparam int unsigned ADDR_W    = 14;
  localparam int          MAX_WORDS = 16384;
  localparam logic [7:0]  MAGIC     = 8'hA5;

  typedef struct { logic [13:0] addr; logic [31:0] data; int idx; } exp_t;
  typedef struct { logic [13:0] addr; logic [31:0] data; logic [3:0] wea; int cyc; } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic core_rst, done, error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .MAGIC(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] stream[$];
  int   acc_q[$];
  exp_t exp_w[$];
  obs_t obs[$];
  int   m_out;      // 0 none, 1 done, 2 error
  bit   exp_done, exp_err;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write pulse with the cycle it is visible in
  always @(negedge clk) begin
    if (bus.imem_ena === 1'b1) begin
      obs_t o;
      o.addr = bus.imem_addra; o.data = bus.imem_dina; o.wea = bus.imem_wea; o.cyc = cyc;
      obs.push_back(o);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: parse the byte stream at frame level
  task automatic run_model();
    int p, n, sz;
    logic [7:0] sum;
    exp_t e;
    exp_w.delete();
    m_out = 0;
    p = 0;
    sz = stream.size();
    while (p < sz && m_out != 1) begin
      if (stream[p] != MAGIC) begin
        p++;
        continue;
      end
      if (p + 2 >= sz) return;
      n = int'({stream[p+2], stream[p+1]});
      p += 3;
      if (n > MAX_WORDS) begin
        m_out = 2;
        continue;
      end
      sum = 8'h00;
      for (int k = 0; k < n; k++) begin
        if (p + 4*k + 3 >= sz) return;
        e.data = {stream[p+4*k+3], stream[p+4*k+2], stream[p+4*k+1], stream[p+4*k]};
        sum = sum + stream[p+4*k] + stream[p+4*k+1] + stream[p+4*k+2] + stream[p+4*k+3];
        e.addr = 14'(k);
        e.idx  = p + 4*k + 3;
        exp_w.push_back(e);
      end
      p += 4*n;
      if (p >= sz) return;
      m_out = (stream[p] == sum) ? 1 : 2;
      p++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max, output int acc);
    int idle;
    idle = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
    acc = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      if (bus.rx_ready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL send_byte: byte %h never accepted (rx_ready stuck low)", b);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_done = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic run_frame(input int gap, input string name);
    int a;
    obs.delete();
    acc_q.delete();
    run_model();
    foreach (stream[i]) begin
      send_byte(stream[i], gap, a);
      acc_q.push_back(a);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    if (m_out == 1) begin exp_done = 1'b1; exp_err = 1'b0; end
    if (m_out == 2) begin exp_done = 1'b0; exp_err = 1'b1; end
    checks++;
    if (done !== exp_done) begin
      errors++; $display("FAIL %s done: got %b expected %b", name, done, exp_done);
    end
    checks++;
    if (error !== exp_err) begin
      errors++; $display("FAIL %s error: got %b expected %b", name, error, exp_err);
    end
    checks++;
    if (core_rst !== !exp_done) begin
      errors++; $display("FAIL %s core_rst: got %b expected %b", name, core_rst, !exp_done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (obs.size() !== exp_w.size()) begin
      errors++; $display("FAIL %s write_count: got %0d expected %0d", name, obs.size(), exp_w.size());
    end else begin
      foreach (exp_w[i]) begin
        checks++;
        if (obs[i].addr !== exp_w[i].addr || obs[i].data !== exp_w[i].data ||
            obs[i].wea !== 4'hF || obs[i].cyc !== acc_q[exp_w[i].idx] + 1) begin
          errors++;
          $display("FAIL %s write%0d: got addr=%h data=%h wea=%h cyc=%0d expected addr=%h data=%h wea=f cyc=%0d",
                   name, i, obs[i].addr, obs[i].data, obs[i].wea, obs[i].cyc,
                   exp_w[i].addr, exp_w[i].data, acc_q[exp_w[i].idx] + 1);
        end
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (bus.imem_ena !== 1'b0 || bus.imem_wea !== 4'h0 || bus.imem_addra !== 14'h0 ||
        bus.imem_dina !== 32'h0) begin
      errors++;
      $display("FAIL %s imem_port: got ena=%b wea=%h addra=%h dina=%h expected 0 0 0 0",
               name, bus.imem_ena, bus.imem_wea, bus.imem_addra, bus.imem_dina);
    end
    checks++;
    if (core_rst !== 1'b1 || done !== 1'b0 || error !== 1'b0 || bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s status: got core_rst=%b done=%b error=%b rx_ready=%b expected 1 0 0 1",
               name, core_rst, done, error, bus.rx_ready);
    end
  endtask

  task automatic load_frame1();
    stream = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    check_reset_values("reset");
  endtask

  task automatic test_basic();
    apply_reset();
    load_frame1();
    run_frame(0, "basic");
  endtask

  task automatic test_bad_csum();
    apply_reset();
    load_frame1();
    stream[11] = 8'h4D;
    run_frame(0, "bad_csum");
    stream = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame(2, "empty_after_err");
  endtask

  task automatic test_garbage();
    apply_reset();
    stream = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    run_frame(1, "garbage");
  endtask

  task automatic test_len_overflow();
    apply_reset();
    stream = '{8'hA5, 8'h01, 8'h40};
    run_frame(0, "len_overflow");
  endtask

  task automatic test_random_gaps();
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      load_frame1();
      run_frame(5, "random_gaps");
    end
  endtask

  task automatic test_reset_midframe();
    int a;
    apply_reset();
    obs.delete();
    stream = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56};
    foreach (stream[i]) send_byte(stream[i], 0, a);
    @(negedge clk);
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    #1;
    check_reset_values("midframe_rst");
    repeat (3) @(negedge clk);
    checks++;
    if (obs.size() !== 0) begin
      errors++; $display("FAIL midframe_rst no_write: got %0d writes expected 0", obs.size());
    end
    rst = 1'b1;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    load_frame1();
    run_frame(0, "after_midframe_rst");
  endtask

  task automatic test_done_hold();
    obs.delete();
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = MAGIC;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rx_ready !== 1'b0 || done !== 1'b1 || core_rst !== 1'b0 || error !== 1'b0) begin
        errors++;
        $display("FAIL done_hold: got rx_ready=%b done=%b core_rst=%b error=%b expected 0 1 0 0",
                 bus.rx_ready, done, core_rst, error);
      end
    end
    bus.rx_valid = 1'b0;
    checks++;
    if (obs.size() !== 0) begin
      errors++; $display("FAIL done_hold no_write: got %0d writes expected 0", obs.size());
    end
  endtask

  task automatic test_random_frames();
    int n;
    logic [7:0] s8, b;
    bit bad;
    for (int it = 0; it < 6; it++) begin
      n   = int'($urandom_range(6, 1));
      bad = ($urandom_range(2, 0) == 0);
      apply_reset();
      stream.delete();
      stream.push_back(8'h3C);
      stream.push_back(MAGIC);
      stream.push_back(8'(n));
      stream.push_back(8'h00);
      s8 = 8'h00;
      for (int k = 0; k < 4*n; k++) begin
        b = 8'($urandom);
        stream.push_back(b);
        s8 = s8 + b;
      end
      stream.push_back(bad ? (s8 ^ 8'h01) : s8);
      run_frame(it % 4, "random_frame");
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_basic();
    test_bad_csum();
    test_garbage();
    test_len_overflow();
    test_random_gaps();
    test_reset_midframe();
    test_done_hold();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
